simon_control_core: RTL and testbench
=====================================

SIMON_CONTROL_CORE -- requirements
Module: simon_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and nReset as in the codebase.
REQ-002 Parameter N, default 16, SHALL set the word size in bits.
REQ-003 Parameter M, default 4, SHALL set the number of key words.
REQ-004 Parameter T, default 32, SHALL set the number of rounds; only the defaults (SIMON32/64, z0 sequence) SHALL be supported.
REQ-005 clk  input  1  SHALL be the rising-edge clock.
REQ-006 nReset  input  1  SHALL be the synchronous reset; value 1 resets the block.
REQ-007 plain  input  2N  SHALL be the plaintext; [2N-1:N] is word x, [N-1:0] is word y.
REQ-008 key  input  M x N (packed [M-1:0][N-1:0])  SHALL be the key; key[0] is k0, the first round key.
REQ-009 cipher  output  2N  SHALL be the ciphertext {x,y}.
REQ-010 done  output  1  SHALL be high when cipher holds the final result.
REQ-011 count  output  32-bit signed int  SHALL be the number of completed rounds.

Function
REQ-012 The block SHALL have three states: LOAD, RUN and DONE; reset forces LOAD.
REQ-013 On the first clock edge with nReset=0 in LOAD, the block SHALL capture x, y and key[0..3] into the state and key-window registers, set count=0 and go to RUN.
REQ-014 Inputs SHALL be sampled only in LOAD; later changes SHALL be ignored until the next reset.
REQ-015 Each RUN cycle SHALL apply one round: x' = y ^ ((x<<<1) & (x<<<8)) ^ (x<<<2) ^ k_i, y' = x, where k_i is the head of the key window and i = count.
REQ-016 Each RUN cycle SHALL advance the key window: tmp = (k[i+3]>>>3) ^ k[i+1]; tmp ^= tmp>>>1; k[i+4] = ~k[i] ^ tmp ^ z0[i] ^ 3.
REQ-017 z0 SHALL be the 62-bit constant 11111010001001010110000111001101111101000100101011000011100110, indexed from the leftmost bit (bit 0 first), modulo 62.
REQ-018 count SHALL increment once per RUN cycle; after round T-1 is applied (count becomes T), the state SHALL go to DONE.
REQ-019 In DONE, done SHALL be 1, count SHALL hold at T, and cipher SHALL hold the result until reset.
REQ-020 done SHALL rise exactly T+1 clock edges after the first edge with nReset=0 (1 load edge plus T round edges).
REQ-021 All rotations SHALL be circular within N bits; all arithmetic SHALL be bitwise only.

Reset
REQ-022 While nReset=1 at a clock edge, the block SHALL set state=LOAD, done=0, count=0, cipher=0 and clear all internal registers.
REQ-023 Reset asserted in RUN or DONE SHALL abort the operation; on release, a new encryption SHALL start from LOAD with the current inputs.
REQ-024 Holding nReset=1 permanently SHALL keep all outputs at their reset values.

Configuration
REQ-025 The macro SIMON_CIPHER_MASK_EN SHALL control cipher visibility during an operation.
REQ-026 With SIMON_CIPHER_MASK_EN defined, cipher SHALL read 0 whenever done=0.
REQ-027 Without SIMON_CIPHER_MASK_EN, cipher SHALL continuously show the live round state {x,y}; this equals plain after LOAD.
REQ-028 The final cipher value, done timing and count SHALL be identical in both builds.

Verification
REQ-029 Known answer: key={1918,1110,0908,0100}, plain=65656877, release reset -> after 33 edges done=1, count=32, cipher=c69be9bb.
REQ-030 Input change: change plain and key mid-RUN -> the result SHALL still be c69be9bb.
REQ-031 Mid-run reset: assert nReset at count=10, release it -> done=0 and count=0 in reset, then the full result after 33 more edges.
REQ-032 Hold in DONE: run 100 extra cycles after done -> done, count=32 and cipher SHALL stay stable.
REQ-033 Mask build: with SIMON_CIPHER_MASK_EN, cipher=0 on every cycle before done, then c69be9bb; without it, cipher=65656877 on the cycle after LOAD.
REQ-034 Count trace: count SHALL step 0,1,...,32, incrementing by exactly 1 per edge after LOAD.

Source files
------------

// File: rtl/simon_control_core.sv
// SIMON32/64 iterative encryption core: one round per clock, key schedule computed on the fly.
// Define SIMON_CIPHER_MASK_EN to force cipher to zero until the final result is available.
module simon_control_core #(
  parameter int unsigned N = 16,
  parameter int unsigned M = 4,
  parameter int unsigned T = 32
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic [2*N-1:0]           plain,
  input  logic [M-1:0][N-1:0]      key,
  output logic [2*N-1:0]           cipher,
  output logic                     done,
  output logic signed [31:0]       count
);

  localparam int unsigned ZLEN = 62;
  localparam logic [ZLEN-1:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [N-1:0] KCONST = N'(3);

`ifdef SIMON_CIPHER_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  state_t               state;
  logic [N-1:0]         x, y;
  logic [M-1:0][N-1:0]  kwin;
  logic [5:0]           zidx;

  logic [N-1:0]         x_next, k_next, tmp0, tmp1;
  logic                 zbit;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
    return (v >> s) | (v << (N - s));
  endfunction

  // Round function and next key word; z0 is indexed from its leftmost bit.
  always_comb begin
    x_next = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ kwin[0];
    tmp0   = ror(kwin[M-1], 3) ^ kwin[1];
    tmp1   = tmp0 ^ ror(tmp0, 1);
    zbit   = Z0[6'(ZLEN - 1) - zidx];
    k_next = ~kwin[0] ^ tmp1 ^ {{(N-1){1'b0}}, zbit} ^ KCONST;
  end

  always_ff @(posedge clk) begin
    if (nReset) begin
      state  <= LOAD;
      x      <= '0;
      y      <= '0;
      kwin   <= '0;
      zidx   <= '0;
      count  <= '0;
      done   <= 1'b0;
      cipher <= '0;
    end else begin
      case (state)
        LOAD: begin
          x      <= plain[2*N-1:N];
          y      <= plain[N-1:0];
          kwin   <= key;
          zidx   <= '0;
          count  <= '0;
          cipher <= MASK ? '0 : plain;
          state  <= RUN;
        end
        RUN: begin
          x     <= x_next;
          y     <= x;
          kwin  <= {k_next, kwin[M-1:1]};
          zidx  <= (zidx == 6'(ZLEN - 1)) ? 6'd0 : zidx + 6'd1;
          count <= count + 32'sd1;
          // Final round: publish the result in both builds.
          if (count == 32'(T - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            cipher <= {x_next, x};
          end else begin
            cipher <= MASK ? '0 : {x_next, x};
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_control_core.sv
// Directed bench for simon_control_core using the SIMON32/64 known-answer vector.
// Expectations follow SIMON_CIPHER_MASK_EN when the bench is built with it.
module tb_simon_control_core;

  localparam logic [31:0] PLAIN  = 32'h6565_6877;
  localparam logic [31:0] RESULT = 32'hc69b_e9bb;
  localparam logic [31:0] ROUND1 = 32'hbca2_6565;

`ifdef SIMON_CIPHER_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic               clk;
  logic               nReset;
  logic [31:0]        plain;
  logic [3:0][15:0]   key;
  logic [31:0]        cipher;
  logic               done;
  logic signed [31:0] count;

  int checks = 0;
  int errors = 0;

  simon_control_core dut (
    .clk    (clk),
    .nReset (nReset),
    .plain  (plain),
    .key    (key),
    .cipher (cipher),
    .done   (done),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_kat();
    plain = PLAIN;
    key   = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
  endtask

  initial begin
    nReset = 1'b1;
    set_kat();

    // Held reset keeps all outputs cleared.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_done", 64'(done), 64'(0));
      check("rst_count", 64'(count), 64'(0));
      check("rst_cipher", 64'(cipher), 64'(0));
    end

    // Load edge.
    nReset = 1'b0;
    tick();
    check("load_count", 64'(count), 64'(0));
    check("load_done", 64'(done), 64'(0));
    check("load_cipher", 64'(cipher), MASK ? 64'(0) : 64'(PLAIN));

    // 32 round edges; inputs scrambled mid-run must be ignored.
    for (int r = 1; r <= 32; r++) begin
      tick();
      check("run_count", 64'(count), 64'(r));
      check("run_done", 64'(done), (r == 32) ? 64'(1) : 64'(0));
      if (r == 1 && !MASK) check("round1_cipher", 64'(cipher), 64'(ROUND1));
      if (MASK && r < 32) check("masked_cipher", 64'(cipher), 64'(0));
      if (r == 5) begin
        plain = 32'hdead_beef;
        key   = {16'h1234, 16'h5678, 16'h9abc, 16'hdef0};
      end
    end
    check("kat_cipher", 64'(cipher), 64'(RESULT));

    // Result holds in DONE.
    for (int i = 0; i < 100; i++) begin
      tick();
      check("hold_done", 64'(done), 64'(1));
      check("hold_count", 64'(count), 64'(32));
      check("hold_cipher", 64'(cipher), 64'(RESULT));
    end

    // Restart, then abort at count=10.
    set_kat();
    nReset = 1'b1;
    tick();
    nReset = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) tick();
    check("abort_pre_count", 64'(count), 64'(10));
    nReset = 1'b1;
    tick();
    check("abort_done", 64'(done), 64'(0));
    check("abort_count", 64'(count), 64'(0));
    check("abort_cipher", 64'(cipher), 64'(0));

    // Fresh run after abort: done appears on exactly the 33rd edge.
    nReset = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      tick();
      check("rerun_count", 64'(count), 64'(e - 1));
      check("rerun_done", 64'(done), (e == 33) ? 64'(1) : 64'(0));
    end
    check("rerun_cipher", 64'(cipher), 64'(RESULT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
